mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single four-bank stalling memory between the instruction-cache controller (I) and the data-cache controller (D).
- Grants the memory port to one requester at a time and holds the grant across a locked line transfer (4-word writeback plus 4-word allocate).
- Routes returning read data to the requester that issued the read, using a latency-tracking tag pipe.
- Sits between both cache controllers and the memory model.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
RD_LAT, 2, cycles from accepted mem_rd to valid mem_data_out

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
i_rd  in  1  I read request
i_wr  in  1  I write request
i_lock  in  1  I holds grant across a multi-access transfer
i_addr  in  ADDR_W  I address
i_data_in  in  DATA_W  I write data
i_stall  out  1  I request not accepted this cycle
i_data_valid  out  1  mem_data_out belongs to an I read
d_rd, d_wr, d_lock, d_addr, d_data_in, d_stall, d_data_valid: D equivalents, same directions and widths
rd_data  out  DATA_W  returned read data (mem_data_out passthrough)
mem_rd  out  1  memory read
mem_wr  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_data_in  out  DATA_W  memory write data
mem_data_out  in  DATA_W  memory read data
mem_stall  in  1  memory cannot accept the access
mem_busy  in  4  per-bank busy, observed only
owner  out  2  00 none, 01 I, 10 D
err  out  1  one-cycle pulse, illegal request

Behaviour:
- FSM states: IDLE, OWN_I, OWN_D. Register last_d (1 = D most recently granted).
- Reset (rst low, asynchronous):
  - state = IDLE, last_d = 0, tag pipe cleared, err = 0.
  - While rst is low: mem_rd = mem_wr = 0, mem_addr = 0, mem_data_in = 0, both data_valid = 0, owner = 00, both stalls = 1.
- Request: x_req = x_rd ^ x_wr.
- Illegal request: x_rd & x_wr.
  - The request is never forwarded and x_stall = 0.
  - err = 1 in the following cycle.
  - The request does not count as a request for arbitration.
- IDLE, combinational winner selection:
  - Only one x_req: that requester wins.
  - Both requesting: D wins if last_d = 0, else I wins (round-robin).
  - The winner's rd/wr/addr/data are forwarded to memory in the same cycle; winner stall = mem_stall; loser stall = 1.
  - owner shows the winner that cycle.
  - On the clock edge, last_d is updated to the winner.
  - If winner lock = 1, the next state is OWN_winner; otherwise the FSM stays in IDLE.
  - No request: owner = 00, mem_rd = mem_wr = 0, stalls = 0.
- OWN_x:
  - Only x is forwarded; x_stall = mem_stall; the other requester's stall = 1 whenever it requests.
  - If x_lock = 0 and x_req = 0, the next state is IDLE. Release is seen one cycle later and the other requester may win from then on.
  - If x_lock = 0 and x_req = 1, the access is forwarded and the next state is IDLE.
- Forwarded signals are zero for the non-winner. mem_wr, mem_rd, mem_addr and mem_data_in are purely combinational from the winner's inputs.
- Tag pipe:
  - RD_LAT stages, each holding {valid, id}.
  - Push {1, id} when mem_rd & ~mem_stall; otherwise push {0, x}. The pipe advances every cycle regardless of stalls.
  - At pipe output valid: assert i_data_valid (id = I) or d_data_valid (id = D) for exactly one cycle.
  - rd_data = mem_data_out at all times.
  - The owner may change while reads are in flight; routing depends only on id.
- Writes produce no data_valid.
- mem_busy does not affect arbitration; the memory's own stall covers it.
- Reset mid-transfer drops all in-flight tags; no data_valid is produced after rst deasserts until a new read is accepted.

Test Plan:
- I read 0x0010 alone, mem_stall = 0 → mem_rd = 1, mem_addr = 0x0010 in the same cycle; i_data_valid = 1 exactly 2 cycles later; d_data_valid stays 0.
- I and D both read in IDLE after reset, no lock → D wins first (owner = 10, i_stall = 1), I wins the next cycle; continuing contention alternates D, I, D.
- D asserts d_lock and issues 8 accesses (4 writes 0x0800–0x0806, 4 reads 0x1000–0x1006) while I requests continuously → i_stall = 1 for all of D's transfer; I is granted the cycle after D drops lock.
- Owner D sees mem_stall = 1 for 3 cycles on a read → d_stall = 1 for those cycles, no tag pushed until the accepting cycle; exactly 4 d_data_valid pulses for 4 accepted reads.
- D read accepted, then the grant passes to I, which reads on the next cycle → data_valid pulses arrive in issue order: D first, then I.
- i_rd = i_wr = 1 → no memory access, err = 1 for one cycle the next cycle; rst low mid-locked-transfer → owner = 00, no data_valid after release, stalls = 1 during reset.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one stalling memory port between the I- and D-cache
//               controllers and routes read data back with a latency tag pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-cache side
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic              i_lock,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data_in,
    output logic              i_stall,
    output logic              i_data_valid,
    // data-cache side
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data_in,
    output logic              d_stall,
    output logic              d_data_valid,
    // shared read return
    output logic [DATA_W-1:0] rd_data,
    // memory side
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_stall,
    input  logic [3:0]        mem_busy,
    // status
    output logic [1:0]        owner,
    output logic              err
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_OWN_I      = 2'd1;
    localparam logic [1:0] c_OWN_D      = 2'd2;
    localparam logic [1:0] c_OWNER_NONE = 2'b00;
    localparam logic [1:0] c_OWNER_I    = 2'b01;
    localparam logic [1:0] c_OWNER_D    = 2'b10;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_last_d;
    logic              r_err;
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_id;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_i_ill;
    logic              w_d_ill;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_push;
    logic [1:0]        w_owner;
    logic              w_unused_busy;

    // Simultaneous rd+wr is illegal and never counts as a request.
    assign w_i_req = i_rd ^ i_wr;
    assign w_d_req = d_rd ^ d_wr;
    assign w_i_ill = i_rd & i_wr;
    assign w_d_ill = d_rd & d_wr;

    always_comb begin : p_arbitrate
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_owner      = c_OWNER_NONE;
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_grant_d = ~r_last_d;
                    w_grant_i = r_last_d;
                end else begin
                    w_grant_i = w_i_req;
                    w_grant_d = w_d_req;
                end
                if (w_grant_i) begin
                    w_owner = c_OWNER_I;
                    if (i_lock) begin
                        w_next_state = c_OWN_I;
                    end
                end else if (w_grant_d) begin
                    w_owner = c_OWNER_D;
                    if (d_lock) begin
                        w_next_state = c_OWN_D;
                    end
                end
            end
            c_OWN_I: begin
                w_owner   = c_OWNER_I;
                w_grant_i = w_i_req;
                if (!i_lock) begin
                    w_next_state = c_IDLE;
                end
            end
            c_OWN_D: begin
                w_owner   = c_OWNER_D;
                w_grant_d = w_d_req;
                if (!d_lock) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
        // Nothing reaches memory while reset is held, whatever the requesters do.
        if (!rst) begin
            w_grant_i = 1'b0;
            w_grant_d = 1'b0;
            w_owner   = c_OWNER_NONE;
        end
    end

    always_comb begin : p_forward
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if (w_grant_i) begin
            mem_rd      = i_rd;
            mem_wr      = i_wr;
            mem_addr    = i_addr;
            mem_data_in = i_data_in;
        end else if (w_grant_d) begin
            mem_rd      = d_rd;
            mem_wr      = d_wr;
            mem_addr    = d_addr;
            mem_data_in = d_data_in;
        end
    end

    // A legal request that is not the forwarded one is always held off.
    assign i_stall = ~rst | (w_grant_i ? mem_stall : w_i_req);
    assign d_stall = ~rst | (w_grant_d ? mem_stall : w_d_req);
    assign owner   = w_owner;
    assign err     = r_err;
    assign rd_data = mem_data_out;

    assign w_push       = mem_rd & ~mem_stall;
    assign i_data_valid = r_tag_vld[RD_LAT-1] & ~r_tag_id[RD_LAT-1];
    assign d_data_valid = r_tag_vld[RD_LAT-1] &  r_tag_id[RD_LAT-1];

    // Bank busy is informational; the memory's own stall already covers it.
    assign w_unused_busy = ^mem_busy;

    always_ff @(posedge clk or negedge rst) begin : p_state
        if (!rst) begin
            r_state  <= c_IDLE;
            r_last_d <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_i_ill | w_d_ill;
            if ((r_state == c_IDLE) && (w_grant_i || w_grant_d)) begin
                r_last_d <= w_grant_d;
            end
        end
    end

    // Tag pipe advances every cycle; id 1 marks a D read.
    always_ff @(posedge clk or negedge rst) begin : p_tag_pipe
        if (!rst) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_push;
            r_tag_id[0]  <= w_grant_d;
            for (int k = 1; k < RD_LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter: directed test-plan sequences
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;
    localparam int c_NONE = 0;
    localparam int c_I    = 1;
    localparam int c_D    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_rd, i_wr, i_lock, i_stall, i_data_valid;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data_in;
    logic              d_rd, d_wr, d_lock, d_stall, d_data_valid;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data_in;
    logic [DATA_W-1:0] rd_data;
    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_stall;
    logic [3:0]        mem_busy;
    logic [1:0]        owner;
    logic              err;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .i_rd(i_rd), .i_wr(i_wr), .i_lock(i_lock), .i_addr(i_addr),
        .i_data_in(i_data_in), .i_stall(i_stall), .i_data_valid(i_data_valid),
        .d_rd(d_rd), .d_wr(d_wr), .d_lock(d_lock), .d_addr(d_addr),
        .d_data_in(d_data_in), .d_stall(d_stall), .d_data_valid(d_data_valid),
        .rd_data(rd_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_stall(mem_stall), .mem_busy(mem_busy),
        .owner(owner), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: who currently holds a lock, who won the last tie-break,
    // and the reads still owed to each requester.
    typedef struct {
        int id;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   holder   = c_NONE;
    logic last_d   = 1'b0;
    logic prev_ill = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic lock_of(input int who);
        return (who == c_I) ? i_lock : d_lock;
    endfunction

    task automatic model_reset();
        holder   = c_NONE;
        last_d   = 1'b0;
        prev_ill = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset();
        chk("rst_mem_rd",      32'(mem_rd),       32'd0);
        chk("rst_mem_wr",      32'(mem_wr),       32'd0);
        chk("rst_mem_addr",    32'(mem_addr),     32'd0);
        chk("rst_mem_data_in", 32'(mem_data_in),  32'd0);
        chk("rst_owner",       32'(owner),        32'd0);
        chk("rst_i_stall",     32'(i_stall),      32'd1);
        chk("rst_d_stall",     32'(d_stall),      32'd1);
        chk("rst_err",         32'(err),          32'd0);
        chk("rst_i_dv",        32'(i_data_valid), 32'd0);
        chk("rst_d_dv",        32'(d_data_valid), 32'd0);
        model_reset();
    endtask

    task automatic check_cycle();
        logic              ir, dr, e_rd, e_wr;
        int                win;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        exp_t              e;
        ir = i_rd ^ i_wr;
        dr = d_rd ^ d_wr;
        // A lock holder keeps the port; otherwise a sole requester wins and a
        // tie goes to the side that was not granted most recently.
        if (holder != c_NONE)  win = (((holder == c_I) ? ir : dr) != 1'b0) ? holder : c_NONE;
        else if (ir && dr)     win = last_d ? c_I : c_D;
        else if (ir)           win = c_I;
        else if (dr)           win = c_D;
        else                   win = c_NONE;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_data = '0;
        if (win == c_I) begin
            e_rd = i_rd; e_wr = i_wr; e_addr = i_addr; e_data = i_data_in;
        end else if (win == c_D) begin
            e_rd = d_rd; e_wr = d_wr; e_addr = d_addr; e_data = d_data_in;
        end
        chk("mem_rd",      32'(mem_rd),      32'(e_rd));
        chk("mem_wr",      32'(mem_wr),      32'(e_wr));
        chk("mem_addr",    32'(mem_addr),    32'(e_addr));
        chk("mem_data_in", 32'(mem_data_in), 32'(e_data));
        chk("owner",       32'(owner),       32'((holder != c_NONE) ? holder : win));
        chk("i_stall",     32'(i_stall),     32'(ir && !(win == c_I && !mem_stall)));
        chk("d_stall",     32'(d_stall),     32'(dr && !(win == c_D && !mem_stall)));
        chk("err",         32'(err),         32'(prev_ill));
        chk("rd_data",     32'(rd_data),     32'(mem_data_out));
        if (win != c_NONE && e_rd && !mem_stall) begin
            e.id  = win;
            e.due = cyc + RD_LAT;
            exp_q.push_back(e);
        end
        if (holder == c_NONE) begin
            if (win != c_NONE) begin
                last_d = (win == c_D);
                if (lock_of(win)) holder = win;
            end
        end else if (!lock_of(holder)) begin
            holder = c_NONE;
        end
        prev_ill = (i_rd & i_wr) | (d_rd & d_wr);
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst) check_cycle();
        else     check_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_i(input logic rd, input logic wr, input logic lk,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        i_rd = rd; i_wr = wr; i_lock = lk; i_addr = a; i_data_in = d;
    endtask

    task automatic drv_d(input logic rd, input logic wr, input logic lk,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        d_rd = rd; d_wr = wr; d_lock = lk; d_addr = a; d_data_in = d;
    endtask

    task automatic idle_all();
        drv_i(1'b0, 1'b0, 1'b0, '0, '0);
        drv_d(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rand_req(output logic rd, output logic wr, output logic lk,
                            output logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        int op;
        op = int'($urandom_range(0, 9));
        rd = (op >= 4 && op <= 6) || (op == 9);
        wr = (op >= 7);
        lk = ($urandom_range(0, 2) == 0);
        a  = ADDR_W'($urandom);
        d  = DATA_W'($urandom);
    endtask

    // Monitor: every data_valid pulse must match the oldest owed read, on time.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                chk("data_valid_route", 32'({i_data_valid, d_data_valid}),
                    (exp_q[0].id == c_I) ? 32'd2 : 32'd1);
                void'(exp_q.pop_front());
            end else if (i_data_valid || d_data_valid) begin
                chk("data_valid_spurious", 32'({i_data_valid, d_data_valid}), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        idle_all();
        mem_stall    = 1'b0;
        mem_data_out = '0;
        mem_busy     = '0;
        #2 rst = 1'b0;
        model_reset();
        drv_i(1'b1, 1'b0, 1'b0, 16'h0010, '0);
        drv_d(1'b1, 1'b0, 1'b1, 16'h0020, '0);
        repeat (3) tick();
        idle_all();
        #1 rst = 1'b1;
        tick();

        // lone I read
        drv_i(1'b1, 1'b0, 1'b0, 16'h0010, '0);
        tick();
        idle_all();
        repeat (3) tick();

        // contention without lock alternates D, I, D, ...
        drv_i(1'b1, 1'b0, 1'b0, 16'h0100, '0);
        drv_d(1'b1, 1'b0, 1'b0, 16'h0200, '0);
        repeat (5) tick();
        idle_all();
        tick();

        // D locked line transfer while I keeps requesting
        drv_d(1'b0, 1'b1, 1'b1, 16'h0800, 16'hA000);
        tick();
        drv_i(1'b1, 1'b0, 1'b0, 16'h0300, '0);
        for (int k = 1; k < 8; k++) begin
            if (k < 4) drv_d(1'b0, 1'b1, 1'b1, 16'h0800 + 16'(2 * k), 16'hA000 + 16'(k));
            else       drv_d(1'b1, 1'b0, (k != 7), 16'h1000 + 16'(2 * (k - 4)), '0);
            tick();
        end
        drv_d(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) tick();
        idle_all();
        repeat (3) tick();

        // memory stall holds off the owner's read
        mem_stall = 1'b1;
        drv_d(1'b1, 1'b0, 1'b1, 16'h1100, '0);
        repeat (3) tick();
        mem_stall = 1'b0;
        tick();
        for (int k = 1; k < 4; k++) begin
            drv_d(1'b1, 1'b0, (k != 3), 16'h1100 + 16'(2 * k), '0);
            tick();
        end
        idle_all();
        repeat (3) tick();

        // D read then I read on back-to-back cycles
        drv_d(1'b1, 1'b0, 1'b0, 16'h1200, '0);
        tick();
        drv_d(1'b0, 1'b0, 1'b0, '0, '0);
        drv_i(1'b1, 1'b0, 1'b0, 16'h0400, '0);
        tick();
        idle_all();
        repeat (3) tick();

        // illegal requests
        drv_i(1'b1, 1'b1, 1'b0, 16'h0500, 16'h1234);
        tick();
        idle_all();
        tick();
        drv_d(1'b1, 1'b1, 1'b0, 16'h0600, 16'h5678);
        drv_i(1'b1, 1'b0, 1'b0, 16'h0502, '0);
        tick();
        idle_all();
        repeat (2) tick();

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            rand_req(i_rd, i_wr, i_lock, i_addr, i_data_in);
            rand_req(d_rd, d_wr, d_lock, d_addr, d_data_in);
            mem_stall    = ($urandom_range(0, 3) == 0);
            mem_data_out = DATA_W'($urandom);
            mem_busy     = 4'($urandom);
            tick();
        end
        idle_all();
        mem_stall = 1'b0;
        repeat (4) tick();

        // reset in the middle of a locked D transfer
        drv_d(1'b1, 1'b0, 1'b1, 16'h1300, '0);
        tick();
        drv_d(1'b1, 1'b0, 1'b1, 16'h1302, '0);
        drv_i(1'b1, 1'b0, 1'b0, 16'h0600, '0);
        tick();
        drv_d(1'b1, 1'b0, 1'b1, 16'h1304, '0);
        #1 rst = 1'b0;
        model_reset();
        repeat (3) tick();
        idle_all();
        #1 rst = 1'b1;
        repeat (RD_LAT + 3) tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
